time_manager: RTL
=================

Name: time_manager

Overview:
- Opposite end of the per-clock event interface. Each clock generator publishes its next event time (time_clock) and compares it against a shared time_next.
- This block collects all N_CLK time_clock values and drives the single time_next back to every clock. Only the earliest clocks fire in a given emulator cycle.
- Adds run/stop/step control, an emulated-time register, an event counter and a monotonicity checker.
- Sits at the top of the emulator, one instance per clock domain group.

Parameters:
- N_CLK, 2, number of clock generators served (1..16).
- TIME_W, 32, width of time words; equals TIME_WIDTH of the time format.
- CNT_W, 32, width of event_count.

Ports:
- clk  in  1  emulator clock.
- rst  in  1  asynchronous reset, active-low.
- time_clock_flat  in  N_CLK*TIME_W  concatenated next-event times; clock i at bits [i*TIME_W +: TIME_W].
- run  in  1  level; 1 = free-run, 0 = pause.
- step  in  1  single-cycle pulse; dispatch exactly one event time while paused.
- stop_time  in  TIME_W  halt threshold (see Optional Feature).
- time_next  out  TIME_W  time broadcast to clocks; combinational from registered state and inputs.
- time_now  out  TIME_W  last dispatched time, registered.
- event_count  out  CNT_W  number of dispatched event times, registered, saturating.
- active  out  1  1 when time_next is a real event time (not the hold sentinel).
- done  out  1  sticky; set in DONE state.
- mono_err  out  1  sticky monotonicity violation.

Behaviour:
- Reset values (rst low, async): state=IDLE, time_now=0, event_count=0, done=0, mono_err=0. Consequently active=0 and time_next=HOLD.
- HOLD is all-ones ({TIME_W{1'b1}}). A clock never matches HOLD unless its own time is all-ones, which is handled as overflow below.
- t_min is the unsigned minimum over all N_CLK inputs, computed combinationally in one cycle, no pipeline. Ties are irrelevant: equal times fire together.
- The zero-latency path is mandatory. Each clock updates time_clock on the edge following time_eq, so any registered min would fire clocks twice.
- time_next = t_min when active=1, else HOLD.
- active = (state==RUN) or (state==STEP_ARM). It is decoded from the state register only, never from run or step directly.
- State IDLE:
  - run=1 -> RUN.
  - step=1 and run=0 -> STEP_ARM.
- State RUN:
  - Every cycle dispatches t_min.
  - run=0 -> PAUSE.
  - Halt condition true -> DONE.
- State STEP_ARM:
  - Dispatches exactly one cycle, then -> PAUSE.
  - Halt condition takes priority -> DONE.
- State PAUSE:
  - run=1 -> RUN.
  - else step=1 -> STEP_ARM.
  - run has priority over step when both are high.
- State DONE:
  - Terminal; active=0; only reset exits.
- Halt condition, evaluated only on cycles where active=1 and acting on the next state:
  - t_min == all-ones (overflow); or
  - stop-time match (optional feature).
  - The dispatch in the halting cycle still occurs: time_now and event_count update.
- On each dispatch cycle (active=1 and t_min != all-ones):
  - time_now <= t_min.
  - event_count <= event_count+1, saturating at all-ones.
  - If t_min < time_now, set mono_err (sticky). Equal is legal: a clock may schedule at the same time.
- An overflow cycle (t_min all-ones) does not dispatch: time_now and event_count are unchanged.
- Arithmetic: all comparisons unsigned, TIME_W bits, no truncation.
- Reset mid-RUN: outputs return to reset values immediately. time_next goes to HOLD asynchronously with rst.
- step pulse while in RUN or DONE: ignored.

Optional Feature:
- Macro: TM_STOP_TIME_EN.
- Defined: the halt condition additionally includes t_min >= stop_time. The halting dispatch still occurs at that t_min, and the FSM then enters DONE.
- Undefined: stop_time is ignored (port kept, unloaded); only overflow halts.

Test Plan:
- Reset, N_CLK=2, inputs {10,20}, run=0 -> time_next=HOLD, active=0, time_now=0, event_count=0.
- run=1, inputs {10,20}, then clock0 advances to 30 -> cycle 1 time_next=10, cycle 2 time_next=20. time_now=10 then 20; event_count=1 then 2.
- Paused, inputs {5,5}, single step pulse -> exactly one cycle with time_next=5; then PAUSE with time_next=HOLD; event_count=1. Asserting step with run=1 goes to RUN (run priority).
- Force input drop from 40 to 35 after time_now=40 -> mono_err=1 and stays 1. Equal repeat 40,40 -> mono_err stays 0.
- TM_STOP_TIME_EN defined, stop_time=100, times 90,100,110 -> dispatches 90 and 100. Then DONE: done=1, time_next=HOLD, time_now=100, event_count=2. Undefined: 110 also dispatched.
- Both inputs all-ones in RUN -> DONE, done=1, time_now unchanged. Assert rst low mid-RUN -> immediate reset values.

Source files
------------

// File: rtl/time_manager.sv
// time_manager: collects the next-event times of N_CLK clock generators,
// broadcasts the earliest one as time_next, and provides run/stop/step
// control, an emulated-time register, a saturating event counter and a
// sticky monotonicity checker.
// Optional feature macro: TM_STOP_TIME_EN (halt once t_min >= stop_time).
//
// Control semantics: run is a level (1 = free-run, 0 = pause); step is a
// single-cycle pulse honoured only in IDLE/PAUSE while run is low. A
// "dispatch" is any cycle with active=1 and t_min != all-ones.
module time_manager #(
  parameter int N_CLK  = 2,
  parameter int TIME_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CLK*TIME_W-1:0] time_clock_flat,
  input  logic                    run,
  input  logic                    step,
  input  logic [TIME_W-1:0]       stop_time,
  output logic [TIME_W-1:0]       time_next,
  output logic [TIME_W-1:0]       time_now,
  output logic [CNT_W-1:0]        event_count,
  output logic                    active,
  output logic                    done,
  output logic                    mono_err,
  output logic [2:0]              state_dbg
);

  localparam logic [TIME_W-1:0] HOLD = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    STEP_ARM = 3'd2,
    PAUSE    = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e              state_q;
  logic [TIME_W-1:0]   time_now_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                done_q;
  logic                mono_err_q;

  logic [TIME_W-1:0]   t_min;
  logic                overflow;
  logic                halt;
  logic                dispatch;

  // Zero-latency unsigned minimum over every clock's next-event time.
  always_comb begin
    t_min = time_clock_flat[0 +: TIME_W];
    for (int i = 1; i < N_CLK; i++) begin
      if (time_clock_flat[i*TIME_W +: TIME_W] < t_min) begin
        t_min = time_clock_flat[i*TIME_W +: TIME_W];
      end
    end
  end

  // Active is decoded from the state register alone, so time_next falls to
  // HOLD asynchronously together with the reset of the state register.
  assign active    = (state_q == RUN) || (state_q == STEP_ARM);
  assign time_next = active ? t_min : HOLD;
  assign overflow  = (t_min == HOLD);
  assign dispatch  = active && !overflow;

`ifdef TM_STOP_TIME_EN
  // Halt on overflow or when the dispatched time reaches the threshold.
  always_comb begin
    halt = active && (overflow || (t_min >= stop_time));
  end
`else
  logic stop_time_unused;
  assign stop_time_unused = ^stop_time;

  // Only an all-ones minimum halts when the stop threshold is compiled out.
  always_comb begin
    halt = active && overflow;
  end
`endif

  // Saturating increment of the dispatched-event counter.
  always_comb begin
    count_d = (&count_q) ? count_q : count_q + 1'b1;
  end

  // Control FSM plus the time/counter/flag registers it governs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      time_now_q <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      mono_err_q <= 1'b0;
    end else begin
      if (dispatch) begin
        time_now_q <= t_min;
        count_q    <= count_d;
        if (t_min < time_now_q) begin
          mono_err_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= RUN;
          end else if (step) begin
            state_q <= STEP_ARM;
          end
        end
        RUN: begin
          if (halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (!run) begin
            state_q <= PAUSE;
          end
        end
        STEP_ARM: begin
          if (halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= PAUSE;
          end
        end
        PAUSE: begin
          if (run) begin
            state_q <= RUN;
          end else if (step) begin
            state_q <= STEP_ARM;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign time_now    = time_now_q;
  assign event_count = count_q;
  assign done        = done_q;
  assign mono_err    = mono_err_q;
  assign state_dbg   = state_q;

endmodule
